// File: rtl/if_fetch_queue_pkg.sv
// Shared CPU constants used by the pipeline segments.
//   XLEN_DEFAULT     : default PC / instruction width
//   INSN_STEP        : byte distance between sequential instructions
//   RESET_PC_DEFAULT : default first fetch address after reset
package if_fetch_queue_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam int          INSN_STEP        = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// fetch_fifo: circular queue of fetched {pc, instruction} records.
// Ports:
//   clk, rst (async, active-low)
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push       : write push_data at the tail
//   push_data  : record to enqueue
//   pop        : retire the head record
//   head_data  : record at the head (meaningful only while count != 0)
//   count      : number of valid records
// The caller never pushes when full nor pops when empty, so no guards here.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head_ptr;
    logic [AW-1:0]    tail_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + AW'(1);
            if (pop)  head_ptr <= head_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail_ptr] <= push_data;
    end

    assign head_data = mem[head_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch unit with a small decoupling queue.
// Ports:
//   clk, rst (async, active-low)
//   imem_req / imem_addr        : fetch request; memory answers one cycle later
//   imem_rvalid / imem_rdata    : response to the previous cycle's request
//   redir_valid / redir_pc      : redirect from EX; flushes queue and in-flight work
//   out_valid / out_ready       : head handshake to decode
//   out_pc / out_npc / out_ir   : head PC, PC+4 and instruction word
// Handshake: a record moves to decode on every rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready, and out_* hold
// steady while out_valid=1 and out_ready=0. The imem side has no back-pressure:
// every imem_req is accepted and answered by imem_rvalid exactly one cycle later.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_npc,
    output logic [XLEN-1:0] out_ir
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   inflight_pc;
    logic              inflight;
    logic              squash;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occupancy;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head_data;

    // Reserve a slot for the outstanding request so a response always fits.
    assign occupancy = count + CW'(inflight);
    assign imem_req  = rst && !redir_valid && (occupancy < CW'(DEPTH));
    assign imem_addr = fetch_pc;

    // A response is kept only if it belongs to a live request: inflight blocks
    // responses issued before reset, squash blocks those issued before a
    // redirect, and a redirect in the arrival cycle wins as well.
    assign push = imem_rvalid && inflight && !squash && !redir_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            squash      <= 1'b0;
        end else begin
            inflight <= imem_req;
            squash   <= redir_valid;
            if (imem_req) inflight_pc <= fetch_pc;
            // Redirect target is taken as-is, alignment is not checked.
            if (redir_valid)   fetch_pc <= redir_pc;
            else if (imem_req) fetch_pc <= fetch_pc + XLEN'(INSN_STEP);
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head_data[2*XLEN-1:XLEN];
    assign out_ir    = head_data[XLEN-1:0];
    assign out_npc   = out_pc + XLEN'(INSN_STEP);

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the fetch-queue entry count; legal values are powers of two, 2..16.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-007 imem_addr  output  XLEN  fetch address, valid when imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid; asserted exactly one cycle after each accepted imem_req.
REQ-009 imem_rdata  input  XLEN  instruction word.
REQ-010 redir_valid  input  1  control-flow redirect from EX (taken branch/jump).
REQ-011 redir_pc  input  XLEN  redirect target.
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_ready  input  1  decode accepts head; transfer when out_valid and out_ready are both 1.
REQ-014 out_pc  output  XLEN  PC of the head instruction.
REQ-015 out_npc  output  XLEN  out_pc+4, modulo 2^XLEN.
REQ-016 out_ir  output  XLEN  head instruction word.

Function
REQ-017 fetch_pc register: imem_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 (modulo 2^XLEN, wrap 0xFFFF_FFFC to 0) on each cycle imem_req=1.
REQ-018 imem_req SHALL be 1 when rst=1, redir_valid=0, and (count + inflight) < DEPTH, where inflight is the number of requests issued in the previous cycle (0 or 1).
REQ-019 Each response SHALL be pushed as {pc, rdata} at the queue tail in the cycle imem_rvalid=1 unless squashed; the pc is the imem_addr of the matching request.
REQ-020 Push and pop in the same cycle SHALL both occur; count is unchanged; a full queue can never receive a push because of REQ-018.
REQ-021 Pop on empty SHALL be impossible (out_valid=0); out_* values are don't-care while out_valid=0.
REQ-022 Fetch-to-out latency SHALL be 2 cycles: request in cycle N, response in N+1, out_valid=1 in N+2 when the queue was empty.
REQ-023 redir_valid=1 in cycle N SHALL clear the queue (count=0), set fetch_pc=redir_pc, suppress imem_req in cycle N, and drop any imem_rvalid response arriving in cycle N+1 (squash flag).
REQ-024 After a redirect in cycle N, out_valid SHALL be 0 in cycles N+1 and N+2, the first request to redir_pc SHALL issue in N+1, and its instruction SHALL appear at the head in N+3.
REQ-025 redir_valid takes priority over a simultaneous push or pop; a same-cycle pop still counts as transferred to decode.
REQ-026 redir_pc SHALL be used unaligned as given; no alignment checking.
REQ-027 Back-to-back redirects SHALL each restart per REQ-023; only the last target is fetched.

Reset
REQ-028 While rst=0: fetch_pc=RESET_PC, count=0, head/tail pointers=0, inflight=0, squash=0, out_valid=0, imem_req=0.
REQ-029 Reset asserted mid-operation SHALL discard queue contents and any outstanding response immediately; the first request after release SHALL be RESET_PC in the first cycle with rst=1.

Structure
REQ-030 The XLEN default, instruction-step constant 4, and RESET_PC default SHALL live in the shared CPU package used by the pipeline segments.
REQ-031 The queue storage/pointers SHALL be one sub-module, fetch_fifo (parameters WIDTH=2*XLEN, DEPTH, with a synchronous flush input); PC, squash, and request logic stay in the top level.

Verification
REQ-032 Reset release, out_ready=1, memory returning addr as data -> requests 0x0,0x4,0x8... on consecutive cycles; first out_valid is 2 cycles after the first request, with out_pc=0, out_npc=4, out_ir=0.
REQ-033 out_ready=0 held 10 cycles, DEPTH=4 -> exactly 4 entries queued (PCs 0x0-0xC), imem_req=0 afterwards, no lost or duplicated entries once out_ready=1.
REQ-034 redir_valid with redir_pc=0x100 while queue holds 3 entries and a request is in flight -> queue empty, stale response dropped, next out_pc=0x100 three cycles after redirect.
REQ-035 Simultaneous push and pop on a full-minus-one queue -> count unchanged, order preserved.
REQ-036 redir_pc=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; out_npc for 0xFFFF_FFFC equals 0x0.
REQ-037 rst asserted mid-stream for 1 cycle -> out_valid=0 immediately, first request after release is RESET_PC.
